// File: rtl/common_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : common_types_pkg
//  Brief    : Shared execute-stage types: multiplier state and iteration count.
//  Revision : 1.0
// ============================================================================
package common_types_pkg;

    localparam int MULT_XLEN       = 32;
    localparam int MULT_RADIX_BITS = 2;
    localparam int MULT_ITER       = MULT_XLEN / MULT_RADIX_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage : common_types_pkg
`default_nettype wire

// File: rtl/execute_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : execute_multiplier
//  Brief    : Iterative signed/unsigned XLEN x XLEN multiplier (MUL/MULH/
//             MULHSU/MULHU) that stalls decode_to_execute while pending.
//  Revision : 1.0
// ============================================================================
module execute_multiplier
    import common_types_pkg::*;
#(
    parameter int XLEN       = MULT_XLEN,
    parameter int RADIX_BITS = MULT_RADIX_BITS
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            start,
    input  logic            flush,
    input  logic            mult_half,
    input  logic            mult_signed_a,
    input  logic            mult_signed_b,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int ITER  = XLEN / RADIX_BITS;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int PW    = 2 * XLEN;

    mult_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [PW-1:0]    r_mcand;
    logic [PW-1:0]    r_acc;
    logic [XLEN-1:0]  r_mplier;
    logic             r_neg;
    logic             r_half;
    logic             r_done;
    logic [XLEN-1:0]  r_result;

    logic             w_load;
    logic [PW-1:0]    w_pp;
    logic [PW-1:0]    w_acc_next;
    logic [PW-1:0]    w_prod;

    // Magnitude fits in XLEN bits as an unsigned value, including 2^(XLEN-1).
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? (~x + XLEN'(1)) : x;
    endfunction

    assign w_load     = start && !flush && (r_state == IDLE || r_state == DONE);
    assign w_pp       = r_mcand * PW'(r_mplier[RADIX_BITS-1:0]);
    assign w_acc_next = r_acc + w_pp;
    assign w_prod     = r_neg ? (~w_acc_next + PW'(1)) : w_acc_next;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_half   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (flush) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: r_state <= IDLE;
                CALC: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << RADIX_BITS;
                    r_mplier <= r_mplier >> RADIX_BITS;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        r_state  <= DONE;
                        r_done   <= 1'b1;
                        r_result <= r_half ? w_prod[PW-1:XLEN] : w_prod[XLEN-1:0];
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            // A start in DONE chains the next operation without an idle cycle.
            if (w_load) begin
                r_state  <= CALC;
                r_mcand  <= PW'(mag(a, mult_signed_a));
                r_mplier <= mag(b, mult_signed_b);
                r_neg    <= (mult_signed_a & a[XLEN-1]) ^ (mult_signed_b & b[XLEN-1]);
                r_half   <= mult_half;
                r_acc    <= '0;
                r_cnt    <= CNT_W'(ITER - 1);
            end
        end
    end

    // The completing instruction retires in DONE, so that cycle never stalls.
    assign stall  = !flush && ((r_state == IDLE && start) || r_state == CALC);
    assign busy   = (r_state == CALC);
    assign done   = r_done;
    assign result = r_result;

endmodule : execute_multiplier
`default_nettype wire

// File: tb/tb_execute_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_execute_multiplier
//  Brief    : Self-checking bench for execute_multiplier against a wide
//             arithmetic reference product.
//  Revision : 1.0
// ============================================================================
module tb_execute_multiplier;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic        flush;
    logic        mult_half;
    logic        mult_signed_a;
    logic        mult_signed_b;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int vectors     = 0;
    int miscompares = 0;

    execute_multiplier dut (
        .clk           (clk),
        .nrst          (nrst),
        .start         (start),
        .flush         (flush),
        .mult_half     (mult_half),
        .mult_signed_a (mult_signed_a),
        .mult_signed_b (mult_signed_b),
        .a             (a),
        .b             (b),
        .busy          (busy),
        .stall         (stall),
        .done          (done),
        .result        (result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input bit half, input bit sa, input bit sb);
        logic signed [65:0] px, py, p;
        px = sa ? {{34{x[31]}}, x} : {34'b0, x};
        py = sb ? {{34{y[31]}}, y} : {34'b0, y};
        p  = px * py;
        return half ? p[63:32] : p[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] x, input logic [31:0] y,
                         input bit half, input bit sa, input bit sb);
        a             = x;
        b             = y;
        mult_half     = half;
        mult_signed_a = sa;
        mult_signed_b = sb;
        start         = 1'b1;
    endtask

    // Called at the negedge where start is driven; returns at the done cycle.
    task automatic complete(input logic [31:0] exp, input string tag);
        int k, st;
        bit seen;
        k = 0; st = 0; seen = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (done) seen = 1;
            else if (stall) st++;
        end
        chk({tag, "_seen"},   64'(seen), 64'd1);
        chk({tag, "_lat"},    64'(k), 64'd17);
        chk({tag, "_stalls"}, 64'(st), 64'd16);
        chk({tag, "_result"}, 64'(result), 64'(exp));
        chk({tag, "_stall0"}, 64'(stall), 64'd0);
        chk({tag, "_busy0"},  64'(busy), 64'd0);
    endtask

    initial begin
        int cnt;
        logic [31:0] x, y;
        bit h, sa, sb;

        nrst = 1'b0; start = 1'b0; flush = 1'b0;
        mult_half = 1'b0; mult_signed_a = 1'b0; mult_signed_b = 1'b0;
        a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   64'(busy), 64'd0);
        chk("rst_done",   64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_stall",  64'(stall), 64'd0);
        nrst = 1'b1;
        @(negedge clk);

        issue(32'd3, 32'd5, 0, 0, 0);
        #1 chk("issue_stall", 64'(stall), 64'd1);
        complete(32'h0000000F, "mul3x5");
        @(negedge clk);
        chk("mul3x5_pulse", 64'(done), 64'd0);
        chk("mul3x5_hold",  64'(result), 64'h0000000F);
        chk("mul3x5_idle",  64'(busy), 64'd0);

        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 1); complete(32'h00000000, "mulh_m1");
        @(negedge clk);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 1); complete(32'h00000001, "mul_m1");
        @(negedge clk);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 0); complete(32'hFFFFFFFE, "mulhu_max");
        @(negedge clk);
        issue(32'hFFFFFFFF, 32'h00000002, 1, 1, 0); complete(32'hFFFFFFFF, "mulhsu");
        @(negedge clk);
        issue(32'h80000000, 32'h80000000, 1, 1, 1); complete(32'h40000000, "mulh_min");
        @(negedge clk);

        // Flush on the fifth CALC cycle.
        issue(32'd1234, 32'd5678, 0, 0, 0);
        repeat (5) begin @(negedge clk); start = 1'b0; end
        chk("pre_flush_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        #1 chk("flush_stall", 64'(stall), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_busy",  64'(busy), 64'd0);
        chk("flush_done",  64'(done), 64'd0);
        chk("flush_stall0", 64'(stall), 64'd0);
        cnt = 0;
        repeat (20) begin @(negedge clk); if (done) cnt++; end
        chk("flush_nodone", 64'(cnt), 64'd0);
        issue(32'd1234, 32'd5678, 0, 0, 0); complete(ref_mul(32'd1234, 32'd5678, 0, 0, 0), "post_flush");

        // Back-to-back: next op issued in the DONE cycle.
        @(negedge clk);
        issue(32'd100, 32'd100, 0, 0, 0); complete(32'd10000, "b2b_first");
        issue(32'd7, 32'd6, 0, 0, 0);
        #1 chk("b2b_done_stall", 64'(stall), 64'd0);
        complete(32'h0000002A, "b2b_second");
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            x  = $urandom;
            y  = $urandom;
            if (i % 6 == 0) x = 32'h80000000;
            if (i % 8 == 3) y = 32'h80000000;
            h  = 1'($urandom_range(0, 1));
            sa = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            issue(x, y, h, sa, sb);
            complete(ref_mul(x, y, h, sa, sb), $sformatf("rnd%0d", i));
            if (i % 2 == 1) @(negedge clk);
        end
        @(negedge clk);

        // Reset mid-CALC; start held during reset must be ignored.
        issue(32'd9, 32'd9, 0, 0, 0);
        repeat (5) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        chk("midrst_busy",   64'(busy), 64'd0);
        chk("midrst_done",   64'(done), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        @(negedge clk);
        chk("rst_start_busy", 64'(busy), 64'd0);
        nrst = 1'b1;
        start = 1'b0;
        cnt = 0;
        repeat (20) begin @(negedge clk); if (done || busy) cnt++; end
        chk("rst_start_ignored", 64'(cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_execute_multiplier
`default_nettype wire
